// File: rtl/attendance_pkg.sv
// Shared definitions for the attendance register.
//   att_state_e : sequencer states. IDLE accepts a class; EVAL walks the
//                 students one per cycle.
//   PCT_SCALE   : the whole-percentage scale that both sides of the
//                 threshold comparison are multiplied up to.
package attendance_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EVAL = 1'b1
  } att_state_e;

  localparam int PCT_SCALE = 100;

endpackage

// File: rtl/att_eval.sv
// Combinational attendance evaluation for a single student.
// The top time-shares one copy of this block across all students.
// Ports:
//   current   : classes attended by the student
//   total     : classes held this term
//   is_safe   : PCT_SCALE*current >= THRESH_PCT*total (exact)
//   leaves    : further absences allowed while staying safe (saturating)
//   to_attend : consecutive attendances needed to become safe (saturating)
//   fa        : full attendance (total != 0 and current == total)
module att_eval
  import attendance_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int LV_W       = 4,
  parameter int THRESH_PCT = 75
)(
  input  logic [CNT_W-1:0] current,
  input  logic [CNT_W-1:0] total,
  output logic             is_safe,
  output logic [LV_W-1:0]  leaves,
  output logic [CNT_W-1:0] to_attend,
  output logic             fa
);

  // Seven extra bits hold any product by a factor below 128, so neither
  // scaled term nor the rounded-up deficit can wrap.
  localparam int PW = CNT_W + 7;
  localparam int GAP_PCT = PCT_SCALE - THRESH_PCT;

  logic [PW-1:0] att_scaled;
  logic [PW-1:0] need_scaled;
  logic [PW-1:0] surplus;
  logic [PW-1:0] deficit;
  logic [PW-1:0] leaves_full;
  logic [PW-1:0] to_full;

  always_comb begin
    att_scaled  = PW'(current) * PW'(PCT_SCALE);
    need_scaled = PW'(total) * PW'(THRESH_PCT);
    is_safe     = (att_scaled >= need_scaled);
    surplus     = is_safe ? (att_scaled - need_scaled) : '0;
    deficit     = is_safe ? '0 : (need_scaled - att_scaled);
    // Each absence raises the requirement by THRESH_PCT without adding to
    // attendance, so the surplus is spent THRESH_PCT at a time.
    leaves_full = surplus / PW'(THRESH_PCT);
    // Each attendance closes the gap by (100 - THRESH_PCT); round up.
    to_full     = (deficit + PW'(GAP_PCT - 1)) / PW'(GAP_PCT);

    if (|(leaves_full >> LV_W)) leaves = '1;
    else                        leaves = LV_W'(leaves_full);

    if (|(to_full >> CNT_W)) to_attend = '1;
    else                     to_attend = CNT_W'(to_full);

    fa = (total != '0) && (current == total);
  end

endmodule

// File: rtl/attendance_register_multi.sv
// Multi-student attendance register.
// A class is accepted on a rising edge with class_valid && class_ready;
// the presence vector is sampled on that edge. The block then spends
// NUM_STUDENTS cycles in EVAL re-evaluating each student's status through
// one shared att_eval, after which class_ready returns.
// Handshake: a transfer happens exactly on an edge where class_valid and
// class_ready are both high; class_ready never depends on class_valid, and
// present is ignored on every other edge.
// Optional feature macro: ATT_STREAK_EN adds parameter ABS_LIMIT and output
// absent_alert (per-student consecutive-absence alarm).
// Ports:
//   clk, clr_n        : clock, asynchronous active-low reset
//   term_clr          : synchronous clear of the whole term
//   class_valid/ready : class offer handshake, present = attendance bits
//   sel               : student whose status drives the sel_* outputs
//   total_classes     : classes held this term
//   sel_current, sel_leaves, sel_to_attend, sel_is_safe, sel_fa : status
//   safe_vec          : is_safe of every student
//   absent_alert      : (ATT_STREAK_EN only) absence streak reached limit
//   term_over         : total_classes == MAX_CLASSES
//   state_dbg         : current sequencer state
module attendance_register_multi
  import attendance_pkg::*;
#(
  parameter int NUM_STUDENTS = 4,
  parameter int MAX_CLASSES  = 100,
  parameter int THRESH_PCT   = 75,
  parameter int LV_W         = 4,
`ifdef ATT_STREAK_EN
  parameter int ABS_LIMIT    = 3,
`endif
  localparam int CNT_W = $clog2(MAX_CLASSES + 1),
  localparam int SEL_W = (NUM_STUDENTS > 1) ? $clog2(NUM_STUDENTS) : 1
)(
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    term_clr,
  input  logic                    class_valid,
  input  logic [NUM_STUDENTS-1:0] present,
  output logic                    class_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [CNT_W-1:0]        total_classes,
  output logic [CNT_W-1:0]        sel_current,
  output logic [LV_W-1:0]         sel_leaves,
  output logic [CNT_W-1:0]        sel_to_attend,
  output logic                    sel_is_safe,
  output logic                    sel_fa,
  output logic [NUM_STUDENTS-1:0] safe_vec,
`ifdef ATT_STREAK_EN
  output logic [NUM_STUDENTS-1:0] absent_alert,
`endif
  output logic                    term_over,
  output att_state_e              state_dbg
);

  att_state_e state;
  att_state_e state_nxt;

  logic [SEL_W-1:0] idx;
  logic             idx_last;
  logic             xfer;
  logic             eval_en;

  logic [CNT_W-1:0] total_r;
  logic [CNT_W-1:0] cur_r       [NUM_STUDENTS];
  logic             safe_r      [NUM_STUDENTS];
  logic [LV_W-1:0]  leaves_r    [NUM_STUDENTS];
  logic [CNT_W-1:0] to_attend_r [NUM_STUDENTS];
  logic             fa_r        [NUM_STUDENTS];

  logic             ev_safe;
  logic [LV_W-1:0]  ev_leaves;
  logic [CNT_W-1:0] ev_to_attend;
  logic             ev_fa;

  assign term_over = (32'(total_r) == MAX_CLASSES);
  assign idx_last  = (32'(idx) == NUM_STUDENTS - 1);
  assign state_dbg = state;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (term_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (xfer) state_nxt = EVAL;
        EVAL:    if (idx_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    class_ready = (state == IDLE) && !term_over && !term_clr;
    xfer        = class_valid && class_ready;
    eval_en     = (state == EVAL) && !term_clr;
  end

  // Shared evaluator, fed with the post-update counters of student idx.
  att_eval #(
    .CNT_W      (CNT_W),
    .LV_W       (LV_W),
    .THRESH_PCT (THRESH_PCT)
  ) u_eval (
    .current   (cur_r[idx]),
    .total     (total_r),
    .is_safe   (ev_safe),
    .leaves    (ev_leaves),
    .to_attend (ev_to_attend),
    .fa        (ev_fa)
  );

  // ---------------- counters and status registers ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      total_r <= '0;
      idx     <= '0;
      for (int i = 0; i < NUM_STUDENTS; i++) begin
        cur_r[i]       <= '0;
        safe_r[i]      <= 1'b1;
        leaves_r[i]    <= '0;
        to_attend_r[i] <= '0;
        fa_r[i]        <= 1'b0;
      end
    end else if (term_clr) begin
      total_r <= '0;
      idx     <= '0;
      for (int i = 0; i < NUM_STUDENTS; i++) begin
        cur_r[i]       <= '0;
        safe_r[i]      <= 1'b1;
        leaves_r[i]    <= '0;
        to_attend_r[i] <= '0;
        fa_r[i]        <= 1'b0;
      end
    end else begin
      if (xfer) begin
        total_r <= total_r + 1'b1;
        idx     <= '0;
        for (int i = 0; i < NUM_STUDENTS; i++) begin
          cur_r[i] <= cur_r[i] + CNT_W'(present[i]);
        end
      end
      if (eval_en) begin
        safe_r[idx]      <= ev_safe;
        leaves_r[idx]    <= ev_leaves;
        to_attend_r[idx] <= ev_to_attend;
        fa_r[idx]        <= ev_fa;
        idx              <= idx + 1'b1;
      end
    end
  end

`ifdef ATT_STREAK_EN
  localparam int STK_W = (ABS_LIMIT > 1) ? $clog2(ABS_LIMIT + 1) : 1;

  logic [STK_W-1:0] streak_r [NUM_STUDENTS];

  // Consecutive-absence counters advance only on accepted classes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_STUDENTS; i++) streak_r[i] <= '0;
    end else if (term_clr) begin
      for (int i = 0; i < NUM_STUDENTS; i++) streak_r[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NUM_STUDENTS; i++) begin
        if (present[i])                          streak_r[i] <= '0;
        else if (32'(streak_r[i]) != ABS_LIMIT)  streak_r[i] <= streak_r[i] + 1'b1;
      end
    end
  end

  always_comb begin
    absent_alert = '0;
    for (int i = 0; i < NUM_STUDENTS; i++) begin
      absent_alert[i] = (32'(streak_r[i]) == ABS_LIMIT);
    end
  end
`endif

  // ---------------- query outputs ----------------
  logic             sel_ok;
  logic [SEL_W-1:0] sel_idx;

  always_comb begin
    sel_ok  = (32'(sel) < NUM_STUDENTS);
    sel_idx = sel_ok ? sel : '0;
    total_classes = total_r;
    sel_current   = '0;
    sel_leaves    = '0;
    sel_to_attend = '0;
    sel_is_safe   = 1'b0;
    sel_fa        = 1'b0;
    if (sel_ok) begin
      sel_current   = cur_r[sel_idx];
      sel_leaves    = leaves_r[sel_idx];
      sel_to_attend = to_attend_r[sel_idx];
      sel_is_safe   = safe_r[sel_idx];
      sel_fa        = fa_r[sel_idx];
    end
    safe_vec = '0;
    for (int i = 0; i < NUM_STUDENTS; i++) safe_vec[i] = safe_r[i];
  end

endmodule

// File: tb/tb_attendance_register_multi.sv
// Directed bench for attendance_register_multi with default parameters
// (4 students, 100 classes, 75 % threshold, 4-bit leaves).
module tb_attendance_register_multi;
  import attendance_pkg::*;

  logic       clk;
  logic       clr_n;
  logic       term_clr;
  logic       class_valid;
  logic [3:0] present;
  logic       class_ready;
  logic [1:0] sel;
  logic [6:0] total_classes;
  logic [6:0] sel_current;
  logic [3:0] sel_leaves;
  logic [6:0] sel_to_attend;
  logic       sel_is_safe;
  logic       sel_fa;
  logic [3:0] safe_vec;
`ifdef ATT_STREAK_EN
  logic [3:0] absent_alert;
`endif
  logic       term_over;
  att_state_e state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  attendance_register_multi dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .term_clr      (term_clr),
    .class_valid   (class_valid),
    .present       (present),
    .class_ready   (class_ready),
    .sel           (sel),
    .total_classes (total_classes),
    .sel_current   (sel_current),
    .sel_leaves    (sel_leaves),
    .sel_to_attend (sel_to_attend),
    .sel_is_safe   (sel_is_safe),
    .sel_fa        (sel_fa),
    .safe_vec      (safe_vec),
`ifdef ATT_STREAK_EN
    .absent_alert  (absent_alert),
`endif
    .term_over     (term_over),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic look(input int s);
    sel = 2'(s);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!class_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!class_ready) chk("ready_timeout", 32'(class_ready), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (state_dbg != IDLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg != IDLE) chk("idle_timeout", 32'(state_dbg), 32'(IDLE));
  endtask

  // Offer one class, hold it across one edge, then wait for evaluation.
  task automatic send_class(input logic [3:0] p);
    wait_ready();
    class_valid = 1'b1;
    present     = p;
    @(posedge clk);
    @(negedge clk);
    class_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_term_clr();
    @(negedge clk);
    term_clr = 1'b1;
    @(negedge clk);
    term_clr = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_n       = 1'b0;
    term_clr    = 1'b0;
    class_valid = 1'b0;
    present     = '0;
    sel         = '0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    #1;

    // Reset state
    chk("rst_total", 32'(total_classes), 0);
    chk("rst_safe_vec", 32'(safe_vec), 32'hF);
    chk("rst_ready", 32'(class_ready), 1);
    chk("rst_term_over", 32'(term_over), 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    for (int s = 0; s < 4; s++) begin
      look(s);
      chk("rst_leaves", 32'(sel_leaves), 0);
      chk("rst_to_attend", 32'(sel_to_attend), 0);
      chk("rst_fa", 32'(sel_fa), 0);
      chk("rst_safe", 32'(sel_is_safe), 1);
    end

    // Four classes: student 1 attends only the first
    @(negedge clk);
    send_class(4'b1111);
    send_class(4'b1101);
    send_class(4'b1101);
    send_class(4'b1101);
    chk("c4_total", 32'(total_classes), 4);
    look(0);
    chk("c4_s0_current", 32'(sel_current), 4);
    chk("c4_s0_fa", 32'(sel_fa), 1);
    chk("c4_s0_leaves", 32'(sel_leaves), 1);
    chk("c4_s0_to_attend", 32'(sel_to_attend), 0);
    look(1);
    chk("c4_s1_current", 32'(sel_current), 1);
    chk("c4_s1_safe", 32'(sel_is_safe), 0);
    chk("c4_s1_to_attend", 32'(sel_to_attend), 8);
    chk("c4_s1_leaves", 32'(sel_leaves), 0);
    chk("c4_s1_fa", 32'(sel_fa), 0);
    look(2);
    chk("c4_s2_current", 32'(sel_current), 4);
    chk("c4_safe_vec", 32'(safe_vec), 32'hD);

    // class_valid held high: per-student update timing and 5-cycle cadence
    @(negedge clk);
    present     = 4'b0001;
    class_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_t0_ready", 32'(class_ready), 0);
    chk("hold_t0_total", 32'(total_classes), 5);
    look(3);
    chk("hold_t0_s3_old_leaves", 32'(sel_leaves), 1);
    @(negedge clk);
    chk("hold_t1_ready", 32'(class_ready), 0);
    look(1);
    chk("hold_t1_s1_old_to_attend", 32'(sel_to_attend), 8);
    @(negedge clk);
    chk("hold_t2_ready", 32'(class_ready), 0);
    look(1);
    chk("hold_t2_s1_new_to_attend", 32'(sel_to_attend), 11);
    @(negedge clk);
    chk("hold_t3_ready", 32'(class_ready), 0);
    look(3);
    chk("hold_t3_s3_old_leaves", 32'(sel_leaves), 1);
    @(negedge clk);
    chk("hold_t4_ready", 32'(class_ready), 1);
    chk("hold_t4_state", 32'(state_dbg), 32'(IDLE));
    look(3);
    chk("hold_t4_s3_new_leaves", 32'(sel_leaves), 0);
    @(negedge clk);
    chk("hold_t5_ready", 32'(class_ready), 0);
    chk("hold_t5_total", 32'(total_classes), 6);
    class_valid = 1'b0;
    wait_idle();
    look(0);
    chk("c6_s0_leaves", 32'(sel_leaves), 2);
    chk("c6_s0_fa", 32'(sel_fa), 1);
    look(1);
    chk("c6_s1_to_attend", 32'(sel_to_attend), 14);
    look(3);
    chk("c6_s3_to_attend", 32'(sel_to_attend), 2);
    chk("c6_s3_safe", 32'(sel_is_safe), 0);
    chk("c6_safe_vec", 32'(safe_vec), 32'h1);

    // term_clr during EVAL index 2, with a class pending
    @(negedge clk);
    present     = 4'b1111;
    class_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    class_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    term_clr    = 1'b1;
    class_valid = 1'b1;
    #1;
    chk("tc_ready_low", 32'(class_ready), 0);
    @(negedge clk);
    chk("tc_total", 32'(total_classes), 0);
    chk("tc_state", 32'(state_dbg), 32'(IDLE));
    chk("tc_safe_vec", 32'(safe_vec), 32'hF);
    look(0);
    chk("tc_s0_current", 32'(sel_current), 0);
    chk("tc_s0_leaves", 32'(sel_leaves), 0);
    chk("tc_s0_fa", 32'(sel_fa), 0);
    term_clr    = 1'b0;
    class_valid = 1'b0;
    #1;
    chk("tc_ready_back", 32'(class_ready), 1);
    @(negedge clk);
    chk("tc_total_after", 32'(total_classes), 0);

`ifdef ATT_STREAK_EN
    // Three straight absences of student 2 raise the alert
    send_class(4'b1011);
    send_class(4'b1011);
    chk("stk_two_absences", 32'(absent_alert[2]), 0);
    send_class(4'b1011);
    chk("stk_three_absences", 32'(absent_alert[2]), 1);
    chk("stk_others", 32'(absent_alert & 4'b1011), 0);
    send_class(4'b1111);
    chk("stk_cleared", 32'(absent_alert[2]), 0);
    do_term_clr();
`endif

    // Fill the term: student 3 attends every other class
    for (int i = 0; i < 100; i++) begin
      send_class({(i % 2 == 0), 3'b111});
    end
    chk("full_total", 32'(total_classes), 100);
    chk("full_term_over", 32'(term_over), 1);
    chk("full_ready", 32'(class_ready), 0);
    look(0);
    chk("full_s0_current", 32'(sel_current), 100);
    chk("full_s0_fa", 32'(sel_fa), 1);
    chk("full_s0_leaves_sat", 32'(sel_leaves), 15);
    look(3);
    chk("full_s3_current", 32'(sel_current), 50);
    chk("full_s3_safe", 32'(sel_is_safe), 0);
    chk("full_s3_to_attend", 32'(sel_to_attend), 100);
    chk("full_safe_vec", 32'(safe_vec), 32'h7);

    // 101st class is ignored
    @(negedge clk);
    class_valid = 1'b1;
    present     = 4'b1111;
    repeat (3) @(negedge clk);
    chk("over_total", 32'(total_classes), 100);
    chk("over_state", 32'(state_dbg), 32'(IDLE));
    look(3);
    chk("over_s3_current", 32'(sel_current), 50);
    class_valid = 1'b0;

    do_term_clr();
    chk("end_total", 32'(total_classes), 0);
    chk("end_term_over", 32'(term_over), 0);
    chk("end_ready", 32'(class_ready), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
